// File: rtl/dma_ctrl.sv
// Multi-channel DMA controller: per-channel register file plus a
// round-robin, one-word-at-a-time copy engine on a req/ack memory port.
module dma_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h400)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ack,
  output logic                  irq
);

  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned LW = 16;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(16 * NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD, S_WR, S_UPD} state_t;

  state_t                state;
  logic [NUM_CH-1:0]     done;
  logic [NUM_CH-1:0]     intr_en;
  logic [NUM_CH-1:0]     busy;
  logic [LW-1:0]         len [NUM_CH];
  logic [ADDR_WIDTH-1:0] src [NUM_CH];
  logic [ADDR_WIDTH-1:0] dst [NUM_CH];
  logic [CW-1:0]         last;
  logic [CW-1:0]         cur;

  logic [ADDR_WIDTH-1:0] off;
  logic                  hit;
  logic [CW-1:0]         sel;
  logic [1:0]            word;
  logic [DATA_WIDTH-1:0] rd_val;
  logic [CW-1:0]         grant;
  logic                  last_word;
  logic [NUM_CH-1:0]     busy_left;

  // Register address decode relative to channel 0
  assign off  = addr - BASE_ADDR;
  assign hit  = (off < SPAN) && (off[1:0] == 2'b00);
  assign sel  = off[CW+3:4];
  assign word = off[3:2];

  // Read data mux; start bit always reads 0
  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (word)
        2'd0:    rd_val = DATA_WIDTH'(done[sel]);
        2'd1:    rd_val = DATA_WIDTH'({len[sel], 13'b0, busy[sel], intr_en[sel], 1'b0});
        2'd2:    rd_val = DATA_WIDTH'(src[sel]);
        default: rd_val = DATA_WIDTH'(dst[sel]);
      endcase
    end
  end

  // Round-robin pick: first busy channel after the last one served
  always_comb begin
    logic found;
    grant = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      int unsigned c;
      c = (32'(last) + i) % NUM_CH;
      if (!found && busy[CW'(c)]) begin
        grant = CW'(c);
        found = 1'b1;
      end
    end
  end

  // Channels still owing words once the current word retires
  assign last_word = (len[cur] == LW'(1));
  assign busy_left = busy & ~(last_word ? (NUM_CH'(1) << cur) : '0);

  // Register file, engine FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      last    <= CW'(NUM_CH - 1);
      cur     <= '0;
      done    <= '0;
      intr_en <= '0;
      busy    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        len[i] <= '0;
        src[i] <= '0;
        dst[i] <= '0;
      end
      rdata   <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      irq     <= 1'b0;
    end else begin
      irq <= |(done & intr_en);

      if (valid && !wr_en) rdata <= rd_val;

      if (valid && wr_en && hit) begin
        case (word)
          2'd0: if (wdata[0]) done[sel] <= 1'b0;
          2'd1: if (!busy[sel]) begin
            intr_en[sel] <= wdata[1];
            len[sel]     <= wdata[31:16];
            if (wdata[0]) begin
              if (wdata[31:16] != '0) busy[sel] <= 1'b1;
              else                    done[sel] <= 1'b1;
            end
          end
          2'd2: if (!busy[sel]) src[sel] <= ADDR_WIDTH'(wdata);
          default: if (!busy[sel]) dst[sel] <= ADDR_WIDTH'(wdata);
        endcase
      end

      // Engine updates come last so a done-set beats a same-cycle clear
      case (state)
        S_IDLE: if (|busy) state <= S_ARB;
        S_ARB: begin
          cur    <= grant;
          last   <= grant;
          m_req  <= 1'b1;
          m_we   <= 1'b0;
          m_addr <= src[grant];
          state  <= S_RD;
        end
        S_RD: if (m_ack) begin
          m_we    <= 1'b1;
          m_addr  <= dst[cur];
          m_wdata <= m_rdata;
          state   <= S_WR;
        end
        S_WR: if (m_ack) begin
          m_req <= 1'b0;
          m_we  <= 1'b0;
          state <= S_UPD;
        end
        S_UPD: begin
          src[cur] <= src[cur] + STEP;
          dst[cur] <= dst[cur] + STEP;
          len[cur] <= len[cur] - LW'(1);
          if (last_word) begin
            busy[cur] <= 1'b0;
            done[cur] <= 1'b1;
          end
          state <= (|busy_left) ? S_ARB : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: expected memory transactions are queued
// when a transfer is started and compared as the DUT completes them.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wr_en;
  logic        valid;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;
  logic        irq;
  logic        ack_en;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t sb[$];
  txn_t e;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rd = -1;
  int   pulses = 0;
  logic req_d = 1'b0;
  logic tchk = 1'b0;

  dma_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_en   (wr_en),
    .valid   (valid),
    .wdata   (wdata),
    .rdata   (rdata),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .irq     (irq)
  );

  // Memory model: data is a fixed function of the address
  assign m_ack   = m_req & ack_en;
  assign m_rdata = m_addr ^ 32'h5A5A_0000;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] s, input logic [31:0] d);
    sb.push_back('{1'b0, s, 32'h0});
    sb.push_back('{1'b1, d, s ^ 32'h5A5A_0000});
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    valid = 1'b0; wr_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    valid = 1'b1; wr_en = 1'b0; addr = a;
    @(posedge clk); #1;
    valid = 1'b0;
    d = rdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pop and compare each completed memory handshake
  always @(negedge clk) begin
    if (m_req && !req_d) pulses++;
    req_d = m_req;
    if (reset && m_req && m_ack) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("m_we", 32'(m_we), 32'(e.we));
        check("m_addr", m_addr, e.addr);
        if (e.we) check("m_wdata", m_wdata, e.data);
        if (!m_we && tchk) begin
          if (last_rd >= 0) check("word_gap", 32'(cyc - last_rd), 32'd4);
          last_rd = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a0;
    int          p0;
    int          bad;
    int          n;

    reset = 1'b0; addr = '0; wr_en = 1'b0; valid = 1'b0; wdata = '0; ack_en = 1'b1;
    cycles(2);
    check("rst_rdata", rdata, 32'd0);
    check("rst_m_req", 32'(m_req), 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    cycles(1);

    // Register access and unmapped read
    reg_wr(32'h418, 32'hA5A5_0000);
    reg_rd(32'h418, d); check("reg_rw", d, 32'hA5A5_0000);
    reg_rd(32'h440, d); check("unmapped", d, 32'd0);

    // Single three-word copy on channel 0
    reg_wr(32'h408, 32'h1000);
    reg_wr(32'h40C, 32'h2000);
    for (int i = 0; i < 3; i++) push_word(32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i));
    tchk = 1'b1; last_rd = -1;
    reg_wr(32'h404, 32'h0003_0003);
    wait_drain(100);
    tchk = 1'b0;
    cycles(3);
    reg_rd(32'h400, d); check("copy_done", d, 32'd1);
    check("copy_irq", 32'(irq), 32'd1);
    reg_rd(32'h408, d); check("copy_src", d, 32'h100C);
    reg_rd(32'h40C, d); check("copy_dst", d, 32'h200C);
    reg_rd(32'h404, d); check("copy_ctrl", d, 32'h0000_0002);
    reg_wr(32'h400, 32'd1);
    cycles(2);
    check("irq_clear", 32'(irq), 32'd0);

    // Round-robin between channels 0 and 2 from a fresh arbiter
    reset = 1'b0; cycles(1); reset = 1'b1;
    reg_wr(32'h408, 32'h100);
    reg_wr(32'h40C, 32'h200);
    reg_wr(32'h428, 32'h300);
    reg_wr(32'h42C, 32'h400);
    push_word(32'h100, 32'h200);
    push_word(32'h300, 32'h400);
    push_word(32'h104, 32'h204);
    push_word(32'h304, 32'h404);
    reg_wr(32'h404, 32'h0002_0003);
    reg_wr(32'h424, 32'h0002_0003);
    wait_drain(200);
    cycles(3);
    reg_rd(32'h400, d); check("rr_done0", d, 32'd1);
    reg_rd(32'h420, d); check("rr_done2", d, 32'd1);
    reg_wr(32'h400, 32'd1);
    cycles(2);
    check("rr_irq_hold", 32'(irq), 32'd1);
    reg_rd(32'h400, d); check("rr_clr0", d, 32'd0);
    reg_wr(32'h420, 32'd1);
    cycles(2);
    check("rr_irq_drop", 32'(irq), 32'd0);

    // Zero-length start: immediate done, no memory traffic
    p0 = pulses;
    reg_wr(32'h434, 32'h0000_0003);
    reg_rd(32'h430, d); check("zero_done", d, 32'd1);
    reg_rd(32'h434, d); check("zero_ctrl", d, 32'h0000_0002);
    cycles(4);
    check("zero_pulses", 32'(pulses - p0), 32'd0);
    reg_wr(32'h430, 32'd1);
    check("sb_left", 32'(sb.size()), 32'd0);

    // Backpressure on channel 1, busy lockout, then reset mid-transfer
    ack_en = 1'b0;
    reg_wr(32'h418, 32'h3000);
    reg_wr(32'h41C, 32'h5000);
    push_word(32'h3000, 32'h5000);
    reg_wr(32'h414, 32'h0001_0001);
    n = 0;
    while (!m_req && n < 20) begin
      cycles(1);
      n++;
    end
    check("req_timeout", 32'(m_req), 32'd1);
    a0 = m_addr;
    bad = 0;
    repeat (10) begin
      cycles(1);
      if (m_req !== 1'b1 || m_addr !== a0) bad++;
    end
    check("stall_stable", 32'(bad), 32'd0);
    check("stall_addr", m_addr, 32'h3000);
    reg_wr(32'h418, 32'hFFFF_0000);
    reg_rd(32'h418, d); check("busy_lockout", d, 32'h3000);
    reg_rd(32'h414, d); check("busy_ctrl", d, 32'h0001_0004);
    reset = 1'b0;
    cycles(1);
    check("abort_req", 32'(m_req), 32'd0);
    reset = 1'b1;
    sb.delete();
    ack_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      reg_rd(32'h400 + 32'(4 * i), d);
      check("post_rst_reg", d, 32'd0);
    end
    check("post_rst_irq", 32'(irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
